// File: rtl/mm_ram_arbiter_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
// State enum, word size and line-to-beat conversion.
package mm_ram_arb_pkg;

  typedef enum logic {
    IDLE,
    IBURST
  } arb_state_e;

  localparam int WORD_BYTES = 4;

  function automatic int beats_of(input int width);
    return width / 32;
  endfunction

endpackage

// File: rtl/mm_ram_arbiter_if.sv
// Core-side fetch/data ports plus RAM macro port of the arbiter.
// slave: arbiter view; master: core + RAM model view.
interface mm_ram_arbiter_if #(
  parameter int ADDR_WIDTH        = 16,
  parameter int INSTR_RDATA_WIDTH = 128
);

  logic                         instr_req;
  logic [ADDR_WIDTH-1:0]        instr_addr;
  logic                         instr_gnt;
  logic                         instr_rvalid;
  logic [INSTR_RDATA_WIDTH-1:0] instr_rdata;

  logic                         data_req;
  logic [ADDR_WIDTH-1:0]        data_addr;
  logic                         data_we;
  logic [3:0]                   data_be;
  logic [31:0]                  data_wdata;
  logic                         data_gnt;
  logic                         data_rvalid;
  logic [31:0]                  data_rdata;

  logic                         ram_en;
  logic [ADDR_WIDTH-1:0]        ram_addr;
  logic                         ram_we;
  logic [3:0]                   ram_be;
  logic [31:0]                  ram_wdata;
  logic [31:0]                  ram_rdata;

  modport slave (
    input  instr_req, instr_addr,
    output instr_gnt, instr_rvalid, instr_rdata,
    input  data_req, data_addr, data_we,
    input  data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata,
    output ram_en, ram_addr, ram_we,
    output ram_be, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output instr_req, instr_addr,
    input  instr_gnt, instr_rvalid, instr_rdata,
    output data_req, data_addr, data_we,
    output data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  ram_en, ram_addr, ram_we,
    input  ram_be, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/mm_ram_arbiter_line_asm.sv
// Fetch line assembler: beat counter, line base, line buffer.
// In: start/busy/line_addr/ram_rdata. Out: beat_addr/last_beat/line_rdata.
module mm_ram_line_asm
  import mm_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH        = 16,
  parameter int INSTR_RDATA_WIDTH = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         busy,
  input  logic [ADDR_WIDTH-1:0]        line_addr,
  input  logic [31:0]                  ram_rdata,
  output logic [ADDR_WIDTH-1:0]        beat_addr,
  output logic                         last_beat,
  output logic [INSTR_RDATA_WIDTH-1:0] line_rdata
);

  localparam int N  = beats_of(INSTR_RDATA_WIDTH);
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    ADDR_WIDTH'(N * WORD_BYTES - 1);

  logic [BW-1:0]         beat_cnt;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [ADDR_WIDTH-1:0] start_base;

  assign start_base = line_addr & ~OFF_MASK;
  assign last_beat  = (beat_cnt == BW'(N - 1));

  // Beat 0 goes out in the grant cycle, before line_base is latched.
  assign beat_addr = start ? start_base
                   : (line_base | ADDR_WIDTH'({beat_cnt, 2'b00}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      line_base <= '0;
    end else if (start) begin
      line_base <= start_base;
      beat_cnt  <= (N > 1) ? BW'(1) : '0;
    end else if (busy) begin
      beat_cnt  <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  if (N > 1) begin : g_buf
    logic [31:0] lbuf [N-1];

    // While bursting, ram_rdata carries the beat issued last cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < N - 1; i++) lbuf[i] <= '0;
      end else if (busy) begin
        lbuf[BW'(beat_cnt - 1'b1)] <= ram_rdata;
      end
    end

    always_comb begin
      line_rdata = '0;
      for (int i = 0; i < N - 1; i++)
        line_rdata[32*i +: 32] = lbuf[i];
      line_rdata[32*(N-1) +: 32] = ram_rdata;
    end
  end else begin : g_nobuf
    assign line_rdata = ram_rdata;
  end

endmodule

// File: rtl/mm_ram_arbiter.sv
// Shares one 32-bit single-port RAM between fetch and data ports.
// Ports: clk, rst (async, high), bus (mm_ram_arbiter_if.slave).
module mm_ram_arbiter
  import mm_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH        = 16,
  parameter int INSTR_RDATA_WIDTH = 128,
  parameter int STARVE_LIMIT      = 4
) (
  input logic                clk,
  input logic                rst,
  mm_ram_arbiter_if.slave    bus
);

  localparam int N  = beats_of(INSTR_RDATA_WIDTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e                   state_q, state_d;
  logic [SW-1:0]                starve_q;
  logic                         idle, starving;
  logic                         instr_win, data_win;
  logic                         instr_rv_q, data_rv_q;
  logic [ADDR_WIDTH-1:0]        beat_addr;
  logic                         last_beat;
  logic [INSTR_RDATA_WIDTH-1:0] line_rdata;

  assign idle     = (state_q == IDLE);
  assign starving = (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    instr_win = idle && bus.instr_req
             && (!bus.data_req || starving);
    data_win  = idle && bus.data_req && !instr_win;
  end

  mm_ram_line_asm #(
    .ADDR_WIDTH       (ADDR_WIDTH),
    .INSTR_RDATA_WIDTH(INSTR_RDATA_WIDTH)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .start     (instr_win),
    .busy      (!idle),
    .line_addr (bus.instr_addr),
    .ram_rdata (bus.ram_rdata),
    .beat_addr (beat_addr),
    .last_beat (last_beat),
    .line_rdata(line_rdata)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (instr_win && N > 1) state_d = IBURST;
      IBURST:  if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      instr_rv_q <= 1'b0;
      data_rv_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_rv_q  <= data_win;
      instr_rv_q <= (instr_win && N == 1)
                 || (!idle && last_beat);
      if (instr_win)
        starve_q <= '0;
      else if (data_win && bus.instr_req && !starving)
        starve_q <= starve_q + 1'b1;
    end
  end

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_be    = '0;
    bus.ram_wdata = '0;
    if (!rst) begin
      unique case (1'b1)
        data_win: begin
          bus.ram_en    = 1'b1;
          bus.ram_addr  = bus.data_addr;
          bus.ram_we    = bus.data_we;
          bus.ram_be    = bus.data_be;
          bus.ram_wdata = bus.data_wdata;
        end
        instr_win || !idle: begin
          bus.ram_en    = 1'b1;
          bus.ram_addr  = beat_addr;
          bus.ram_be    = 4'hF;
        end
        default: ;
      endcase
    end
  end

  assign bus.instr_gnt    = instr_win && !rst;
  assign bus.data_gnt     = data_win && !rst;
  assign bus.instr_rvalid = instr_rv_q;
  assign bus.data_rvalid  = data_rv_q;
  assign bus.instr_rdata  = rst ? '0 : line_rdata;
  assign bus.data_rdata   = rst ? '0 : bus.ram_rdata;

endmodule

// File: tb/tb_mm_ram_arbiter.sv
// Directed bench for mm_ram_arbiter: N=4 and N=1 instances,
// each with a behavioural 1-cycle-latency RAM.
module tb_mm_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  mm_ram_arbiter_if #(16, 128) b4 ();
  mm_ram_arbiter_if #(16, 32)  b1 ();

  mm_ram_arbiter #(
    .ADDR_WIDTH(16), .INSTR_RDATA_WIDTH(128), .STARVE_LIMIT(4)
  ) u4 (.clk(clk), .rst(rst), .bus(b4));

  mm_ram_arbiter #(
    .ADDR_WIDTH(16), .INSTR_RDATA_WIDTH(32), .STARVE_LIMIT(4)
  ) u1 (.clk(clk), .rst(rst), .bus(b1));

  logic [31:0] mem4 [16384];
  logic [31:0] mem1 [16384];

  always @(posedge clk) begin
    if (b4.ram_en) begin
      if (b4.ram_we) begin
        for (int k = 0; k < 4; k++)
          if (b4.ram_be[k])
            mem4[b4.ram_addr[15:2]][8*k +: 8] <= b4.ram_wdata[8*k +: 8];
      end else begin
        b4.ram_rdata <= mem4[b4.ram_addr[15:2]];
      end
    end
    if (b1.ram_en) begin
      if (b1.ram_we) begin
        for (int k = 0; k < 4; k++)
          if (b1.ram_be[k])
            mem1[b1.ram_addr[15:2]][8*k +: 8] <= b1.ram_wdata[8*k +: 8];
      end else begin
        b1.ram_rdata <= mem1[b1.ram_addr[15:2]];
      end
    end
  end

  typedef struct {
    logic         ireq;
    logic [15:0]  iaddr;
    logic         dreq;
    logic         dwe;
    logic [15:0]  daddr;
    logic [31:0]  dwdata;
    logic         igt;
    logic         dgt;
    logic         en;
    logic [15:0]  raddr;
    logic         rwe;
    logic         irv;
    logic [127:0] irdata;
    logic         drv;
    logic         dchk;
    logic [31:0]  drdata;
  } vec_t;

  localparam logic [127:0] L1 =
    128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] L2 =
    128'h00000008_00000007_00000006_00000005;
  localparam logic [31:0] DB = 32'hDEADBEEF;

  vec_t t4[$];
  vec_t t1[$];

  function automatic vec_t mk(
    input logic ireq, input logic [15:0] iaddr,
    input logic dreq, input logic dwe,
    input logic [15:0] daddr, input logic [31:0] dwdata,
    input logic igt, input logic dgt, input logic en,
    input logic [15:0] raddr, input logic rwe,
    input logic irv, input logic [127:0] irdata,
    input logic drv, input logic dchk, input logic [31:0] drdata
  );
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
    v.daddr = daddr; v.dwdata = dwdata; v.igt = igt; v.dgt = dgt;
    v.en = en; v.raddr = raddr; v.rwe = rwe; v.irv = irv;
    v.irdata = irdata; v.drv = drv; v.dchk = dchk; v.drdata = drdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit one, input int i);
    logic igt, dgt, en, rwe, irv, drv;
    logic [15:0] raddr;
    logic [127:0] ird;
    logic [31:0] drd;
    string p;
    p = $sformatf("%s%0d", one ? "n1_v" : "n4_v", i);
    @(posedge clk); #1;
    if (one) begin
      b1.instr_req = v.ireq; b1.instr_addr = v.iaddr;
      b1.data_req = v.dreq; b1.data_we = v.dwe;
      b1.data_addr = v.daddr; b1.data_wdata = v.dwdata;
      b1.data_be = 4'hF;
    end else begin
      b4.instr_req = v.ireq; b4.instr_addr = v.iaddr;
      b4.data_req = v.dreq; b4.data_we = v.dwe;
      b4.data_addr = v.daddr; b4.data_wdata = v.dwdata;
      b4.data_be = 4'hF;
    end
    @(negedge clk);
    if (one) begin
      igt = b1.instr_gnt; dgt = b1.data_gnt; en = b1.ram_en;
      raddr = b1.ram_addr; rwe = b1.ram_we;
      irv = b1.instr_rvalid; drv = b1.data_rvalid;
      ird = 128'(b1.instr_rdata); drd = b1.data_rdata;
    end else begin
      igt = b4.instr_gnt; dgt = b4.data_gnt; en = b4.ram_en;
      raddr = b4.ram_addr; rwe = b4.ram_we;
      irv = b4.instr_rvalid; drv = b4.data_rvalid;
      ird = b4.instr_rdata; drd = b4.data_rdata;
    end
    chk({p, "_igt"}, 160'(igt), 160'(v.igt));
    chk({p, "_dgt"}, 160'(dgt), 160'(v.dgt));
    chk({p, "_en"}, 160'(en), 160'(v.en));
    chk({p, "_irv"}, 160'(irv), 160'(v.irv));
    chk({p, "_drv"}, 160'(drv), 160'(v.drv));
    if (v.en) begin
      chk({p, "_addr"}, 160'(raddr), 160'(v.raddr));
      chk({p, "_we"}, 160'(rwe), 160'(v.rwe));
    end
    if (v.irv) chk({p, "_irdata"}, 160'(ird), 160'(v.irdata));
    if (v.dchk) chk({p, "_drdata"}, 160'(drd), 160'(v.drdata));
  endtask

  task automatic idle_all();
    b4.instr_req = 0; b4.data_req = 0; b4.data_we = 0;
    b1.instr_req = 0; b1.data_req = 0; b1.data_we = 0;
  endtask

  initial begin : main
    int lat;
    b4.instr_addr = '0; b4.data_addr = '0;
    b4.data_be = 4'hF; b4.data_wdata = '0;
    b1.instr_addr = '0; b1.data_addr = '0;
    b1.data_be = 4'hF; b1.data_wdata = '0;
    idle_all();
    for (int w = 0; w < 8; w++) mem4[16+w] = 32'(w + 1);
    mem1[16] = 32'hA1;
    mem1[17] = 32'hA2;

    // Reset: requests asserted, every output must stay 0.
    b4.instr_req = 1; b4.data_req = 1;
    b1.instr_req = 1; b1.data_req = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_n4_outs",
        160'({b4.instr_gnt, b4.data_gnt, b4.ram_en, b4.ram_addr,
              b4.instr_rvalid, b4.data_rvalid, b4.instr_rdata}),
        160'(0));
    chk("rst_n1_outs",
        160'({b1.instr_gnt, b1.data_gnt, b1.ram_en, b1.ram_addr,
              b1.instr_rvalid, b1.data_rvalid, b1.instr_rdata}),
        160'(0));
    @(posedge clk); #1;
    idle_all();
    rst = 0;

    t4.push_back(mk(0,0,   0,0,0,0,  0,0,0,0,0,    0,0,  0,0,0));
    t4.push_back(mk(0,0,   1,1,'h10,DB, 0,1,1,'h10,1, 0,0, 0,0,0));
    t4.push_back(mk(0,0,   1,0,'h10,0, 0,1,1,'h10,0,  0,0,  1,0,0));
    t4.push_back(mk(0,0,   0,0,0,0,  0,0,0,0,0,    0,0,  1,1,DB));
    t4.push_back(mk(1,'h44,0,0,0,0,  1,0,1,'h40,0, 0,0,  0,0,0));
    t4.push_back(mk(0,0,   0,0,0,0,  0,0,1,'h44,0, 0,0,  0,0,0));
    t4.push_back(mk(0,0,   0,0,0,0,  0,0,1,'h48,0, 0,0,  0,0,0));
    t4.push_back(mk(0,0,   0,0,0,0,  0,0,1,'h4C,0, 0,0,  0,0,0));
    t4.push_back(mk(0,0,   0,0,0,0,  0,0,0,0,0,    1,L1, 0,0,0));
    t4.push_back(mk(1,'h50,1,0,'h10,0, 0,1,1,'h10,0, 0,0, 0,0,0));
    for (int c = 0; c < 3; c++)
      t4.push_back(mk(1,'h50,1,0,'h10,0, 0,1,1,'h10,0, 0,0, 1,1,DB));
    t4.push_back(mk(1,'h50,1,0,'h10,0, 1,0,1,'h50,0, 0,0, 1,1,DB));
    t4.push_back(mk(0,0,   1,0,'h10,0, 0,0,1,'h54,0, 0,0,  0,0,0));
    t4.push_back(mk(0,0,   1,0,'h10,0, 0,0,1,'h58,0, 0,0,  0,0,0));
    t4.push_back(mk(0,0,   1,0,'h10,0, 0,0,1,'h5C,0, 0,0,  0,0,0));
    t4.push_back(mk(0,0,   1,0,'h10,0, 0,1,1,'h10,0, 1,L2, 0,0,0));
    t4.push_back(mk(0,0,   0,0,0,0,  0,0,0,0,0,    0,0,  1,1,DB));
    t4.push_back(mk(1,'h40,0,0,0,0,  1,0,1,'h40,0, 0,0,  0,0,0));
    t4.push_back(mk(1,'h40,0,0,0,0,  0,0,1,'h44,0, 0,0,  0,0,0));
    t4.push_back(mk(1,'h40,0,0,0,0,  0,0,1,'h48,0, 0,0,  0,0,0));
    t4.push_back(mk(1,'h40,0,0,0,0,  0,0,1,'h4C,0, 0,0,  0,0,0));
    t4.push_back(mk(1,'h50,0,0,0,0,  1,0,1,'h50,0, 1,L1, 0,0,0));
    t4.push_back(mk(1,'h50,0,0,0,0,  0,0,1,'h54,0, 0,0,  0,0,0));
    t4.push_back(mk(1,'h50,0,0,0,0,  0,0,1,'h58,0, 0,0,  0,0,0));
    t4.push_back(mk(1,'h50,0,0,0,0,  0,0,1,'h5C,0, 0,0,  0,0,0));
    t4.push_back(mk(0,0,   0,0,0,0,  0,0,0,0,0,    1,L2, 0,0,0));

    t1.push_back(mk(1,'h40,0,0,0,0,  1,0,1,'h40,0, 0,0,  0,0,0));
    t1.push_back(mk(0,0,   1,0,'h44,0, 0,1,1,'h44,0, 1,'hA1, 0,0,0));
    t1.push_back(mk(1,'h44,0,0,0,0,  1,0,1,'h44,0, 0,0,  1,1,'hA2));
    t1.push_back(mk(0,0,   1,1,'h48,'h55, 0,1,1,'h48,1, 1,'hA2, 0,0,0));
    t1.push_back(mk(1,'h48,1,0,'h48,0, 0,1,1,'h48,0, 0,0, 1,0,0));
    t1.push_back(mk(1,'h48,0,0,0,0,  1,0,1,'h48,0, 0,0,  1,1,'h55));
    t1.push_back(mk(0,0,   0,0,0,0,  0,0,0,0,0,    1,'h55, 0,0,0));

    foreach (t4[i]) run_vec(t4[i], 1'b0, i);
    foreach (t1[i]) run_vec(t1[i], 1'b1, i);

    // Reset in the middle of a burst (during beat 2).
    @(posedge clk); #1;
    b4.instr_req = 1; b4.instr_addr = 16'h44;
    @(negedge clk);
    chk("mb_gnt", 160'(b4.instr_gnt), 160'(1));
    @(posedge clk); #1;
    b4.instr_req = 0;
    @(posedge clk);
    @(negedge clk);
    chk("mb_beat2", 160'(b4.ram_addr), 160'(16'h48));
    rst = 1;
    b4.instr_req = 1; b4.data_req = 1;
    #1;
    chk("mb_rst_outs",
        160'({b4.instr_gnt, b4.data_gnt, b4.ram_en, b4.ram_addr,
              b4.ram_we, b4.ram_be, b4.instr_rvalid,
              b4.data_rvalid, b4.data_rdata, b4.instr_rdata[63:0]}),
        160'(0));
    repeat (2) @(posedge clk);
    #1;
    idle_all();
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("mb_no_rv%0d", c),
          160'({b4.instr_rvalid, b4.ram_en}), 160'(0));
    end

    // Fresh fetch after reset must complete normally.
    @(posedge clk); #1;
    b4.instr_req = 1; b4.instr_addr = 16'h5C;
    @(negedge clk);
    chk("mb_regnt", 160'({b4.instr_gnt, b4.ram_addr}),
        160'({1'b1, 16'h50}));
    lat = 0;
    do begin
      @(posedge clk); #1;
      b4.instr_req = 0;
      lat++;
    end while (!b4.instr_rvalid && lat < 10);
    chk("mb_lat", 160'(lat), 160'(4));
    chk("mb_line", 160'(b4.instr_rdata), 160'(L2));

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mm_ram_arbiter.md
# mm_ram_arbiter

Arbiter and burst sequencer that shares one single-ported, 32-bit-wide synthesizable RAM between the core's instruction-fetch port and its data port. Instruction fetches are wide lines, `INSTR_RDATA_WIDTH` bits, and are serialized into N = `INSTR_RDATA_WIDTH`/32 word beats. Data accesses are single beats. The block sits between the core's OBI-style ports and the RAM macro, replacing the dual-port RAM in area-constrained synthesis builds.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, byte-address width of the RAM.
- `INSTR_RDATA_WIDTH`, 128, fetch line width. Legal values are 32·2^k for k = 0..3, so N ∈ {1,2,4,8}.
- `STARVE_LIMIT`, 4, number of consecutive cycles a waiting fetch may lose to data before it is forced to win. Legal range is ≥1.

Ports (clock and reset first):
- `clk` in 1: the single clock. All state updates on its rising edge.
- `rst` in 1: reset, **asynchronous, active-high**.
- `instr_req` in 1: fetch request. Held until granted.
- `instr_addr` in `ADDR_WIDTH`: fetch byte address. Low log2(N·4) bits are ignored.
- `instr_gnt` out 1: fetch accepted this cycle.
- `instr_rvalid` out 1: fetch line valid.
- `instr_rdata` out `INSTR_RDATA_WIDTH`: line data. Beat k occupies bits [32k+31:32k].
- `data_req` in 1: data request. Held until granted.
- `data_addr` in `ADDR_WIDTH`: data byte address.
- `data_we` in 1: data write enable.
- `data_be` in 4: data byte enables.
- `data_wdata` in 32: data write data.
- `data_gnt` out 1: data accepted this cycle.
- `data_rvalid` out 1: data response valid, for both reads and writes.
- `data_rdata` out 32: read data.
- `ram_en` out 1: RAM access strobe.
- `ram_addr` out `ADDR_WIDTH`: RAM byte address.
- `ram_we` out 1: RAM write enable.
- `ram_be` out 4: RAM byte enables.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data. Valid exactly 1 cycle after `ram_en`.

## Operation
FSM states are IDLE and IBURST.

IDLE, arbitration (combinational grant):
- Only `data_req` asserted: data wins.
- Only `instr_req` asserted: instr wins.
- Both asserted: data wins, unless `starve_cnt` == `STARVE_LIMIT`, in which case instr wins.

Data grant (IDLE only):
- `data_gnt`=1 and `ram_en`=1.
- `ram_addr`/`ram_we`/`ram_be`/`ram_wdata` are driven from the data port.
- `data_rvalid`=1 in the next cycle, with `data_rdata` = `ram_rdata`. For writes, `data_rdata` is don't-care.

Instr grant (IDLE only):
- `instr_gnt`=1 and `ram_en`=1, `ram_we`=0, `ram_be`=4'hF.
- Beat 0 address is `line_base` = `instr_addr` with the low log2(4N) bits cleared. `line_base` is latched.
- If N>1, go to IBURST with `beat_cnt`=1.

IBURST:
- Issue beat `beat_cnt` at `line_base` + 4·`beat_cnt`. Beats never cross a line, so no address wrap occurs.
- Capture each returning beat into the line buffer.
- `instr_gnt`=0 and `data_gnt`=0 throughout. Both requests stay pending.
- After issuing beat N−1, return to IDLE.

Fetch response:
- `instr_rvalid`=1 in the cycle the last beat's `ram_rdata` is valid.
- `instr_rdata` = {`ram_rdata`, buffered beats N−2..0}. The top word is passed straight through.

`starve_cnt` (0..`STARVE_LIMIT`, saturating):
- Increments in each IDLE cycle where `instr_req` is asserted and data is granted.
- Clears on any instr grant.

Each port has at most one outstanding transaction. A new grant on the same port is permitted in the same cycle as its `rvalid`.

## Timing
- Reset values: state=IDLE, `beat_cnt`=0, `starve_cnt`=0, `instr_rvalid`=0, `data_rvalid`=0, line buffer=0. While `rst` is high, every output is forced to 0, including the combinational `gnt` and `ram_en`.
- Data latency: grant at cycle t, `data_rvalid` at t+1.
- Fetch latency: grant at t, beats at t..t+N−1, `instr_rvalid` at t+N. The fabric is back in IDLE at t+N, so a new grant is allowed in that cycle.
- N=1: no IBURST. A fetch behaves like a data read (`rvalid` at t+1).
- Peak throughput: 1 RAM access per cycle. RAM idle cycles occur only when neither request is asserted.
- Reset asserted mid-burst: the FSM returns to IDLE immediately. The partial line is discarded and no `instr_rvalid` is emitted for it.

## Structure
- Package `mm_ram_arb_pkg` holds:
  - the state enum `arb_state_e` {IDLE, IBURST};
  - `WORD_BYTES`=4;
  - function `beats_of(width)` returning width/32.
- Sub-module `mm_ram_line_asm` holds the beat counter, the line-base register and the line buffer, and produces the beat address, last-beat flag and line output.
- The top level holds arbitration, `starve_cnt`, the output muxes and the `rvalid` registers.

## Test plan
- **Data only.** With N=4, issue a data write of 0xDEADBEEF to 0x0010 with `be`=4'hF, then a read of 0x0010. Required: `gnt` in the request cycle, `data_rvalid` one cycle later, read returns 0xDEADBEEF.
- **Fetch line.** With RAM words at 0x40..0x4C preloaded to 1,2,3,4, fetch `instr_addr`=0x0044. Required: `ram_addr` sequence 0x40,0x44,0x48,0x4C, `instr_rvalid` 4 cycles after `gnt`, `instr_rdata`=0x00000004_00000003_00000002_00000001.
- **Priority and starvation.** With `STARVE_LIMIT`=4, hold `data_req` high continuously and assert `instr_req`. Required: data granted 4 consecutive cycles, instr granted on the 5th, `data_gnt` low for the following 4 burst cycles, then data is granted again.
- **Back-to-back.** Hold `instr_req` continuously with N=4. Required: `instr_gnt` every 4 cycles, coinciding with the previous line's `instr_rvalid`, and no idle `ram_en` cycles.
- **Reset mid-burst.** Assert `rst` during beat 2 of a fetch. Required: all outputs 0 immediately, no `instr_rvalid` after release, next fetch completes correctly.
- **N=1 configuration** (`INSTR_RDATA_WIDTH`=32). Issue alternating instr/data requests. Required: single-beat fetches, `instr_rvalid` at t+1, data and instr interleave per the priority rule.
